// File: rtl/entropy_encode_ac_run_level_stream.sv
// AC run/level entropy coder: one coefficient per beat in, one merged run+level+sign codeword per non-zero out.
// Optional AC_BLOCK_BITCOUNT_EN adds a per-block bit total (block_bits / block_bits_valid).
module entropy_encode_ac_run_level_stream #(
    parameter int COEFF_W = 16,
    parameter int RUN_W   = 6,
    parameter int CW_W    = 64,
    parameter int LEN_W   = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COEFF_W-1:0] in_coeff,
    input  logic                      in_sob,
    input  logic                      in_eob,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CW_W-1:0]           out_code,
    output logic [LEN_W-1:0]          out_len,
    output logic                      out_eob
`ifdef AC_BLOCK_BITCOUNT_EN
    ,
    output logic [15:0]               block_bits,
    output logic                      block_bits_valid
`endif
);

    localparam int VW = COEFF_W + 1;
    localparam int WW = COEFF_W + 3;

    function automatic logic [7:0] cb_run(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1:                   cb_run = 8'h06;
            4'd2, 4'd3:                   cb_run = 8'h05;
            4'd4:                         cb_run = 8'h04;
            4'd5, 4'd6, 4'd7, 4'd8:       cb_run = 8'h29;
            4'd15:                        cb_run = 8'h4C;
            default:                      cb_run = 8'h28;
        endcase
    endfunction

    function automatic logic [7:0] cb_level(input logic [3:0] idx);
        case (idx)
            4'd0:                         cb_level = 8'h04;
            4'd1:                         cb_level = 8'h0A;
            4'd2:                         cb_level = 8'h05;
            4'd3:                         cb_level = 8'h06;
            4'd4:                         cb_level = 8'h04;
            4'd9:                         cb_level = 8'h4C;
            default:                      cb_level = 8'h28;
        endcase
    endfunction

    function automatic logic [LEN_W-1:0] msb_index(input logic [WW-1:0] w);
        msb_index = '0;
        for (int i = 0; i < WW; i++) begin
            if (w[i]) msb_index = LEN_W'(i);
        end
    endfunction

    // Leading zeros are implicit: val is right-aligned and len counts them.
    function automatic void cw_field(input logic [VW-1:0] v, input logic [7:0] cb,
                                     output logic [WW-1:0] val, output logic [LEN_W-1:0] len);
        logic [2:0]       rice;
        logic [2:0]       expo;
        logic [1:0]       sw;
        logic [WW-1:0]    first;
        logic [WW-1:0]    vx;
        logic [WW-1:0]    w;
        logic [LEN_W-1:0] e;
        rice  = cb[7:5];
        expo  = cb[4:2];
        sw    = cb[1:0];
        first = WW'({1'b0, sw} + 3'd1) << rice;
        vx    = WW'(v);
        if (vx < first) begin
            val = (WW'(1) << rice) | (vx & ((WW'(1) << rice) - WW'(1)));
            len = LEN_W'(vx >> rice) + LEN_W'(rice) + LEN_W'(1);
        end else begin
            w   = vx - first + (WW'(1) << expo);
            e   = msb_index(w);
            val = w;
            len = e - LEN_W'(expo) + LEN_W'(sw) + e + LEN_W'(1);
        end
    endfunction

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Capture rank
    logic               c0_valid_reg, c0_sob_reg, c0_eob_reg;
    logic [COEFF_W-1:0] c0_coeff_reg;

    // Codebook context
    logic [RUN_W-1:0]   run_reg, prev_run_reg;
    logic [VW-1:0]      prev_level_reg;

    // S1: run tracking, codebook selection, abs/sign
    logic [RUN_W-1:0]   eff_run, eff_prev_run;
    logic [VW-1:0]      eff_prev_level, coeff_ext, abs_c;
    logic [3:0]         run_idx, lev_idx;
    logic               coeff_zero, coeff_neg;

    always_comb begin
        eff_run        = c0_sob_reg ? '0 : run_reg;
        eff_prev_run   = c0_sob_reg ? RUN_W'(4) : prev_run_reg;
        eff_prev_level = c0_sob_reg ? VW'(2) : prev_level_reg;
        coeff_ext      = {c0_coeff_reg[COEFF_W-1], c0_coeff_reg};
        coeff_neg      = c0_coeff_reg[COEFF_W-1];
        coeff_zero     = (c0_coeff_reg == '0);
        abs_c          = coeff_neg ? (~coeff_ext + VW'(1)) : coeff_ext;
        run_idx        = (eff_prev_run > RUN_W'(15)) ? 4'd15 : eff_prev_run[3:0];
        lev_idx        = (eff_prev_level > VW'(9)) ? 4'd9 : eff_prev_level[3:0];
    end

    logic               s1_valid_reg, s1_zero_reg, s1_eob_reg, s1_sign_reg;
    logic [VW-1:0]      s1_run_v_reg, s1_lev_v_reg;
    logic [7:0]         s1_run_cb_reg, s1_lev_cb_reg;

    // S2: exponents and field lengths
    logic [WW-1:0]      run_val_next, lev_val_next;
    logic [LEN_W-1:0]   run_len_next, lev_len_next;

    always_comb begin
        cw_field(s1_run_v_reg, s1_run_cb_reg, run_val_next, run_len_next);
        cw_field(s1_lev_v_reg, s1_lev_cb_reg, lev_val_next, lev_len_next);
    end

    logic               s2_valid_reg, s2_zero_reg, s2_eob_reg, s2_sign_reg;
    logic [WW-1:0]      s2_run_val_reg, s2_lev_val_reg;
    logic [LEN_W-1:0]   s2_run_len_reg, s2_lev_len_reg;

    // S3: concatenation
    logic [CW_W-1:0]    code_next;
    logic [LEN_W-1:0]   len_next;

    always_comb begin
        code_next = '0;
        len_next  = '0;
        if (!s2_zero_reg) begin
            code_next = (CW_W'(s2_run_val_reg) << (s2_lev_len_reg + LEN_W'(1)))
                      | (CW_W'(s2_lev_val_reg) << 1) | CW_W'(s2_sign_reg);
            len_next  = s2_run_len_reg + s2_lev_len_reg + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_reg        <= '0;
            prev_run_reg   <= RUN_W'(4);
            prev_level_reg <= VW'(2);
        end else if (adv && c0_valid_reg) begin
            if (coeff_zero) begin
                run_reg        <= (&eff_run) ? eff_run : eff_run + RUN_W'(1);
                prev_run_reg   <= eff_prev_run;
                prev_level_reg <= eff_prev_level;
            end else begin
                run_reg        <= '0;
                prev_run_reg   <= eff_run;
                prev_level_reg <= abs_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c0_valid_reg   <= 1'b0;
            c0_sob_reg     <= 1'b0;
            c0_eob_reg     <= 1'b0;
            c0_coeff_reg   <= '0;
            s1_valid_reg   <= 1'b0;
            s1_zero_reg    <= 1'b0;
            s1_eob_reg     <= 1'b0;
            s1_sign_reg    <= 1'b0;
            s1_run_v_reg   <= '0;
            s1_lev_v_reg   <= '0;
            s1_run_cb_reg  <= '0;
            s1_lev_cb_reg  <= '0;
            s2_valid_reg   <= 1'b0;
            s2_zero_reg    <= 1'b0;
            s2_eob_reg     <= 1'b0;
            s2_sign_reg    <= 1'b0;
            s2_run_val_reg <= '0;
            s2_lev_val_reg <= '0;
            s2_run_len_reg <= '0;
            s2_lev_len_reg <= '0;
            out_valid      <= 1'b0;
            out_code       <= '0;
            out_len        <= '0;
            out_eob        <= 1'b0;
        end else if (adv) begin
            c0_valid_reg   <= in_valid;
            c0_sob_reg     <= in_sob;
            c0_eob_reg     <= in_eob;
            c0_coeff_reg   <= in_coeff;
            // Zero coefficients only surface as a beat when they close the block.
            s1_valid_reg   <= c0_valid_reg && (!coeff_zero || c0_eob_reg);
            s1_zero_reg    <= coeff_zero;
            s1_eob_reg     <= c0_eob_reg;
            s1_sign_reg    <= coeff_neg;
            s1_run_v_reg   <= VW'(eff_run);
            s1_lev_v_reg   <= abs_c - VW'(1);
            s1_run_cb_reg  <= cb_run(run_idx);
            s1_lev_cb_reg  <= cb_level(lev_idx);
            s2_valid_reg   <= s1_valid_reg;
            s2_zero_reg    <= s1_zero_reg;
            s2_eob_reg     <= s1_eob_reg;
            s2_sign_reg    <= s1_sign_reg;
            s2_run_val_reg <= run_val_next;
            s2_lev_val_reg <= lev_val_next;
            s2_run_len_reg <= run_len_next;
            s2_lev_len_reg <= lev_len_next;
            out_valid      <= s2_valid_reg;
            out_code       <= code_next;
            out_len        <= len_next;
            out_eob        <= s2_eob_reg;
        end
    end

`ifdef AC_BLOCK_BITCOUNT_EN
    logic [15:0] bits_acc_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bits_acc_reg     <= '0;
            block_bits       <= '0;
            block_bits_valid <= 1'b0;
        end else begin
            block_bits_valid <= 1'b0;
            if (out_valid && out_ready) begin
                if (out_eob) begin
                    block_bits       <= bits_acc_reg + 16'(out_len);
                    block_bits_valid <= 1'b1;
                    bits_acc_reg     <= '0;
                end else begin
                    bits_acc_reg     <= bits_acc_reg + 16'(out_len);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_entropy_encode_ac_run_level_stream.sv
// Self-checking bench: a string-level codeword model feeds a scoreboard checked on every accepted beat,
// plus literal checks on the hand-worked scenarios.
module tb_entropy_encode_ac_run_level_stream;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_coeff = '0;
    logic               in_sob = 1'b0;
    logic               in_eob = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [63:0]        out_code;
    logic [6:0]         out_len;
    logic               out_eob;
`ifdef AC_BLOCK_BITCOUNT_EN
    logic [15:0]        block_bits;
    logic               block_bits_valid;
`endif

    entropy_encode_ac_run_level_stream dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coeff  (in_coeff),
        .in_sob    (in_sob),
        .in_eob    (in_eob),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_len   (out_len),
        .out_eob   (out_eob)
`ifdef AC_BLOCK_BITCOUNT_EN
        ,
        .block_bits       (block_bits),
        .block_bits_valid (block_bits_valid)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int stall_start = -100;
    always begin
        @(posedge clk);
        #2;
        out_ready = !(cyc >= stall_start && cyc < stall_start + 5);
    end

    typedef struct {
        logic [63:0] code;
        int          len;
        bit          eob;
    } beat_t;
    beat_t exp_q[$];

    int cbr[16] = '{'h06, 'h06, 'h05, 'h05, 'h04, 'h29, 'h29, 'h29, 'h29, 'h28, 'h28, 'h28, 'h28, 'h28, 'h28, 'h4C};
    int cbl[10] = '{'h04, 'h0A, 'h05, 'h06, 'h04, 'h28, 'h28, 'h28, 'h28, 'h4C};

    int m_run, m_prev_run, m_prev_level;

    function automatic string bit_str(int v, int nbits);
        string s = "";
        for (int i = nbits - 1; i >= 0; i--) s = {s, ((v >> i) & 1) ? "1" : "0"};
        return s;
    endfunction

    function automatic string cw_bits(int v, int cb);
        int    rice = (cb >> 5) & 7;
        int    expo = (cb >> 2) & 7;
        int    sw   = cb & 3;
        int    first = (sw + 1) << rice;
        int    w, e;
        string s = "";
        if (v < first) begin
            for (int i = 0; i < (v >> rice); i++) s = {s, "0"};
            s = {s, "1", bit_str(v, rice)};
        end else begin
            w = v - first + (1 << expo);
            e = 0;
            while ((w >> (e + 1)) != 0) e++;
            for (int i = 0; i < e - expo + sw; i++) s = {s, "0"};
            s = {s, bit_str(w, e + 1)};
        end
        return s;
    endfunction

    task automatic model_reset();
        m_run = 0;
        m_prev_run = 4;
        m_prev_level = 2;
    endtask

    task automatic model_accept(input int c, input bit sob, input bit eob);
        beat_t b;
        string s;
        int    a;
        if (sob) model_reset();
        if (c == 0) begin
            if (eob) begin
                b.code = '0;
                b.len  = 0;
                b.eob  = 1'b1;
                exp_q.push_back(b);
            end
            m_run = (m_run + 1 > 63) ? 63 : m_run + 1;
        end else begin
            a = (c < 0) ? -c : c;
            s = {cw_bits(m_run, cbr[(m_prev_run > 15) ? 15 : m_prev_run]),
                 cw_bits(a - 1, cbl[(m_prev_level > 9) ? 9 : m_prev_level]),
                 (c < 0) ? "1" : "0"};
            b.code = '0;
            for (int i = 0; i < s.len(); i++) b.code = {b.code[62:0], (s[i] == 8'h31)};
            b.len = s.len();
            b.eob = eob;
            exp_q.push_back(b);
            m_prev_run   = m_run;
            m_prev_level = a;
            m_run        = 0;
        end
    endtask

    // Main-process bookkeeping read by the monitor
    int tmo_cnt = 0;
    int first_acc_cyc = 0;
    int nobs_s3 = 0;
    int idx_reset = 0;
    bit done = 1'b0;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input int c, input bit sob, input bit eob);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_coeff = 16'(c);
        in_sob   = sob;
        in_eob   = eob;
        n = 0;
        acc = 1'b0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
            if (acc) break;
            n++;
            if (n > 200) begin
                tmo_cnt++;
                break;
            end
        end
        if (acc) model_accept(c, sob, eob);
        in_valid = 1'b0;
        in_sob   = 1'b0;
        in_eob   = 1'b0;
    endtask

    // Monitor / scoreboard
    int          ncmp = 0;
    int          nfail = 0;
    int          nobs = 0;
    logic [63:0] obs_code[256];
    int          obs_len[256];
    bit          obs_eob[256];
    int          obs_cyc[256];
    bit          hold_pending = 1'b0;
    logic [63:0] h_code;
    logic [6:0]  h_len;
    logic        h_eob;
    int          stall_seen = 0;
`ifdef AC_BLOCK_BITCOUNT_EN
    int          bb_acc = 0;
    bit          bb_pulse = 1'b0;
    int          bb_val = 0;
`endif

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        ncmp++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (done) begin
            chk("s1_code", obs_code[0], 64'h48);
            chk("s1_len", 64'(obs_len[0]), 64'd7);
            chk("s1_eob", 64'(obs_eob[0]), 64'd0);
            chk("s1_latency", 64'(obs_cyc[0] - first_acc_cyc), 64'd3);
            chk("s2_code", obs_code[1], 64'h0D);
            chk("s2_len", 64'(obs_len[1]), 64'd6);
            chk("s3_code", obs_code[2], 64'h0);
            chk("s3_len", 64'(obs_len[2]), 64'd0);
            chk("s3_eob", 64'(obs_eob[2]), 64'd1);
            chk("s3_beat_count", 64'(nobs_s3), 64'd3);
            chk("rst_nosob_code", obs_code[idx_reset], 64'h7);
            chk("rst_nosob_len", 64'(obs_len[idx_reset]), 64'd3);
            chk("rst_sob_code", obs_code[idx_reset + 1], 64'h48);
            chk("rst_sob_len", 64'(obs_len[idx_reset + 1]), 64'd7);
            chk("rst_sob_eob", 64'(obs_eob[idx_reset + 1]), 64'd1);
            chk("stall_exercised", 64'(stall_seen >= 3), 64'd1);
            chk("queue_drained", 64'(exp_q.size()), 64'd0);
            chk("timeouts", 64'(tmo_cnt), 64'd0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
            $finish;
        end else if (reset) begin
            exp_q.delete();
            hold_pending = 1'b0;
            chk("reset_outputs", {out_valid, out_eob, out_len, out_code[31:0]}, 64'h0);
            chk("reset_in_ready", 64'(in_ready), 64'd1);
`ifdef AC_BLOCK_BITCOUNT_EN
            bb_acc = 0;
            bb_pulse = 1'b0;
`endif
        end else begin
            chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (hold_pending) begin
                chk("hold", {out_valid, out_eob, out_len, out_code[54:0]}, {1'b1, h_eob, h_len, h_code[54:0]});
                chk("hold_code", out_code, h_code);
            end
`ifdef AC_BLOCK_BITCOUNT_EN
            chk("bb_valid", 64'(block_bits_valid), 64'(bb_pulse));
            if (bb_pulse) chk("bb_value", 64'(block_bits), 64'(bb_val));
            bb_pulse = 1'b0;
`endif
            if (out_valid && !out_ready) stall_seen++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    ncmp++;
                    nfail++;
                    $display("FAIL unexpected_beat: got code=%0h len=%0d eob=%0d, want no beat", out_code, out_len, out_eob);
                end else begin
                    e = exp_q.pop_front();
                    ncmp++;
                    if (out_code !== e.code || 32'(out_len) !== e.len || out_eob !== e.eob) begin
                        nfail++;
                        $display("FAIL beat%0d: got code=%0h len=%0d eob=%0d, want code=%0h len=%0d eob=%0d",
                                 nobs, out_code, out_len, out_eob, e.code, e.len, e.eob);
                    end
`ifdef AC_BLOCK_BITCOUNT_EN
                    if (e.eob) begin
                        bb_pulse = 1'b1;
                        bb_val   = bb_acc + e.len;
                        bb_acc   = 0;
                    end else begin
                        bb_acc = bb_acc + e.len;
                    end
`endif
                end
                if (nobs < 256) begin
                    obs_code[nobs] = out_code;
                    obs_len[nobs]  = 32'(out_len);
                    obs_eob[nobs]  = out_eob;
                    obs_cyc[nobs]  = cyc;
                end
                nobs++;
                $display("beat %0d: cyc=%0d code=%0h len=%0d eob=%0d", nobs - 1, cyc, out_code, out_len, out_eob);
            end
            hold_pending = out_valid && !out_ready;
            h_code = out_code;
            h_len  = out_len;
            h_eob  = out_eob;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        idle(3);
        reset = 1'b0;

        // Scenarios 1-3: one block, hand-worked codewords
        send(5, 1'b1, 1'b0);
        first_acc_cyc = cyc;
        send(0, 1'b0, 1'b0);
        send(0, 1'b0, 1'b0);
        send(-1, 1'b0, 1'b0);
        send(0, 1'b0, 1'b0);
        send(0, 1'b0, 1'b0);
        send(0, 1'b0, 1'b1);
        idle(8);
        nobs_s3 = nobs;

        // Back-pressure window over a burst
        stall_start = cyc + 4;
        send(3, 1'b1, 1'b0);
        send(-2, 1'b0, 1'b0);
        send(0, 1'b0, 1'b0);
        send(7, 1'b0, 1'b0);
        send(100, 1'b0, 1'b0);
        send(-300, 1'b0, 1'b0);
        send(0, 1'b0, 1'b0);
        send(0, 1'b0, 1'b0);
        send(1, 1'b0, 1'b0);
        send(-1, 1'b0, 1'b1);
        idle(15);

        // Run saturation
        send(1, 1'b1, 1'b0);
        for (int i = 0; i < 70; i++) send(0, 1'b0, 1'b0);
        send(2, 1'b0, 1'b1);
        idle(6);

        // Extreme magnitudes
        send(-32768, 1'b1, 1'b0);
        send(32767, 1'b0, 1'b0);
        send(17, 1'b0, 1'b0);
        send(-32767, 1'b0, 1'b1);
        idle(6);

        // sob discards a pending run; single-coefficient blocks
        send(4, 1'b1, 1'b0);
        send(0, 1'b0, 1'b0);
        send(0, 1'b0, 1'b0);
        send(3, 1'b1, 1'b1);
        send(0, 1'b1, 1'b1);
        send(-6, 1'b1, 1'b1);
        idle(8);

        // Reset mid-run restores codebook defaults
        send(5, 1'b1, 1'b0);
        idle(6);
        send(0, 1'b0, 1'b0);
        send(0, 1'b0, 1'b0);
        reset = 1'b1;
        idx_reset = nobs;
        model_reset();
        idle(2);
        reset = 1'b0;
        send(-1, 1'b0, 1'b0);
        send(5, 1'b1, 1'b1);
        idle(10);

        done = 1'b1;
    end

endmodule

// File: doc/entropy_encode_ac_run_level_stream.md
Name: entropy_encode_ac_run_level_stream

Overview:
- Next-generation AC entropy coder for the ProRes slice path.
- Takes one quantised AC coefficient per cycle in scan order and tracks zero runs.
- For each non-zero coefficient it emits one merged codeword: run code, then level code, then sign bit.
- Adaptive codebook state is reset per block, trailing zeros are suppressed, and the output uses a valid/ready handshake. It feeds the slice bit packer.

Parameters:
- COEFF_W, 16: signed two's-complement coefficient width.
- RUN_W, 6: run counter width; the counter saturates at 2^RUN_W-1.
- CW_W, 64: output codeword width. Must be at least the worst-case length: 12 + (2*COEFF_W-1) + 1.
- LEN_W, 7: codeword length width; CW_W must fit in LEN_W bits.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- in_valid  in  1  coefficient beat valid.
- in_ready  out  1  block can accept a beat.
- in_coeff  in  COEFF_W  signed AC coefficient.
- in_sob  in  1  first AC coefficient of a block.
- in_eob  in  1  last AC coefficient of a block.
- out_valid  out  1  codeword beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_code  out  CW_W  codeword, right-aligned (last bit at LSB, unused upper bits 0).
- out_len  out  LEN_W  codeword length in bits (0 allowed).
- out_eob  out  1  beat closes a block.

Behaviour:
- Reset: out_valid=0, out_code=0, out_len=0, out_eob=0, pipeline valids cleared, run=0, prev_run=4, prev_level=2. in_ready is 1 after reset.
- Handshake:
  - Pipeline advance enable is adv = !out_valid || out_ready. in_ready = adv.
  - A beat is accepted when in_valid && in_ready.
  - While out_valid && !out_ready, out_code, out_len and out_eob are held stable.
- Latency: exactly 3 cycles from the accepting edge to out_valid when never stalled. Throughput is 1 beat per cycle.
  - S1: run tracking, codebook selection, abs/sign.
  - S2: exponent (leading-one) computation and field lengths.
  - S3: concatenation into out_code.
- in_sob: before the beat is processed, sets run=0, prev_run=4, prev_level=2.
  - A run pending from an unfinished block is discarded; no eob is emitted for that block.
- Coefficient == 0: run increments (saturating) and no beat is produced. Exception: if in_eob is set, a beat with out_len=0, out_code=0, out_eob=1 is produced; trailing zeros are never coded.
- Coefficient != 0: one beat is produced, with out_eob=in_eob.
  - The beat is RUNCW(run, cbR[min(prev_run,15)]) ++ CW(|c|-1, cbL[min(prev_level,9)]) ++ sign, with sign=1 when negative.
  - Afterwards: prev_run=run, prev_level=|c|, run=0.
- Codebook byte cb fields: rice_order=cb[7:5], exp_order=cb[4:2], switch=cb[1:0], first_exp=(switch+1)<<rice_order.
  - Run table cbR: 06,06,05,05,04,29,29,29,29,28,28,28,28,28,28,4C (hex).
  - Level table cbL: 04,0A,05,06,04,28,28,28,28,4C (hex).
- CW(v, cb), v < first_exp: (v>>rice_order) zeros, then a 1, then the low rice_order bits of v.
- CW(v, cb), v >= first_exp: let w = v - first_exp + 2^exp_order and e = floor(log2 w). Emit (e - exp_order + switch) zeros, then the e+1 bits of w.
- |c| is computed at COEFF_W+1 bits, so -2^(COEFF_W-1) is legal.
- in_sob and in_eob on the same beat form a one-coefficient block and both take effect.
- Reset mid-operation: all in-flight beats are lost and codebook state returns to its defaults. A block continuing without in_sob is coded from the defaults.

Optional Feature:
- Macro AC_BLOCK_BITCOUNT_EN.
- When defined, adds outputs block_bits (16) and block_bits_valid (1).
  - A per-block accumulator sums out_len of every beat accepted downstream (out_valid && out_ready).
  - On acceptance of an out_eob beat, block_bits is loaded with the block total, block_bits_valid pulses for 1 cycle, and the accumulator clears.
  - Both outputs reset to 0.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then sob with coeff +5 (out_ready=1) -> 3 cycles later out_code=0x48, out_len=7, out_eob=0.
- Continue with 0, 0, -1 -> a single beat out_code=0x0D, out_len=6 (run "001", level "10", sign "1").
- Continue with 0 x3, the last flagged eob -> one beat out_len=0, out_code=0, out_eob=1; no other beats.
- Hold out_ready=0 for 5 cycles mid-stream -> in_ready=0, out beat held bit-identical, no beats lost or duplicated after release.
- Assert reset during the run of scenario 2, then sob with +5 -> 0x48/7 again, proving defaults were restored.
- AC_BLOCK_BITCOUNT_EN defined, scenarios 1-3 -> block_bits=13 with a 1-cycle block_bits_valid pulse on the eob acceptance.
